// File: rtl/imm_rot_encoder.sv
// Multi-cycle search for an ARM rotated immediate: value == imm8 ROR (2*rot).
// Define IMM_ENC_NEG_EN to add a second pass on ~value (MVN/BIC form, flagged by inverted).
module imm_rot_encoder #(
  parameter int TESTS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        found,
  output logic [3:0]  rot,
  output logic [7:0]  imm8,
  output logic        inverted
);

  if (TESTS_PER_CYCLE != 1 && TESTS_PER_CYCLE != 2 && TESTS_PER_CYCLE != 4 &&
      TESTS_PER_CYCLE != 8 && TESTS_PER_CYCLE != 16) begin : g_bad_param
    $error("imm_rot_encoder: TESTS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  // r only ever takes multiples of TESTS_PER_CYCLE below 16, so 4 bits suffice.
  localparam logic [3:0] R_STEP = 4'(TESTS_PER_CYCLE);
  localparam logic [3:0] R_LAST = 4'(16 - TESTS_PER_CYCLE);

  state_t      state;
  logic [31:0] v_q;
  logic [3:0]  r;
  logic        neg_q;

  logic [31:0] cand [TESTS_PER_CYCLE];
  logic        hit;
  logic [3:0]  hit_k;
  logic [7:0]  hit_imm;

  // Candidate k is V ROL 2k; the upper half of the doubled word is the rotated result.
  for (genvar g = 0; g < TESTS_PER_CYCLE; g++) begin : g_cand
    logic [3:0]  k;
    logic [63:0] dbl;
    assign k       = r + 4'(g);
    assign dbl     = {v_q, v_q} << {k, 1'b0};
    assign cand[g] = dbl[63:32];
  end

  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hit     = 1'b0;
    hit_k   = r;
    hit_imm = 8'd0;
    // Walking downward lets the smallest hitting k overwrite larger ones.
    for (int j = TESTS_PER_CYCLE - 1; j >= 0; j--) begin
      if (cand[j][31:8] == 24'd0) begin
        hit     = 1'b1;
        hit_k   = r + 4'(j);
        hit_imm = cand[j][7:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the captured operand is reset too; it is a single register, not
      // a memory, and resetting it keeps the candidate logic X-free after reset.
      state     <= IDLE;
      v_q       <= 32'd0;
      r         <= 4'd0;
      neg_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      found     <= 1'b0;
      rot       <= 4'd0;
      imm8      <= 8'd0;
      inverted  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            v_q      <= value;
            r        <= 4'd0;
            neg_q    <= 1'b0;
            in_ready <= 1'b0;
            state    <= SEARCH;
          end
        end

        SEARCH: begin
          if (hit) begin
            found     <= 1'b1;
            rot       <= hit_k;
            imm8      <= hit_imm;
            inverted  <= neg_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (r == R_LAST) begin
`ifdef IMM_ENC_NEG_EN
            if (!neg_q) begin
              neg_q <= 1'b1;
              v_q   <= ~v_q;
              r     <= 4'd0;
            end else begin
              found     <= 1'b0;
              rot       <= 4'd0;
              imm8      <= 8'd0;
              inverted  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
`else
            found     <= 1'b0;
            rot       <= 4'd0;
            imm8      <= 8'd0;
            inverted  <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
`endif
          end else begin
            r <= r + R_STEP;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
